// File: rtl/hdmi_timing_gen.sv
// Raster counters, sync generation and a registered 24-bit pixel bus for an HDMI transmitter.
// Build macro HDMI_TEST_PATTERN_EN swaps the r/g/b inputs for eight vertical colour bars.
module hdmi_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] x,
  output logic [11:0] y,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        hdmi_clk,
  output logic [23:0] hdmi_d,
  output logic        hdmi_de,
  output logic        hdmi_hs,
  input  logic        blank,
  output logic        hdmi_vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        active;
  logic        hs_raw;
  logic        vs_raw;
  logic [23:0] pixel;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // The coordinate request goes out straight from the counters; the
  // picture generator answers combinationally within the same cycle.
  assign x = h_cnt;
  assign y = v_cnt;

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_raw = (v_cnt >= VS_START) && (v_cnt < VS_END);

`ifdef HDMI_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar;
  logic       unused_rgb;

  // Bar index bits map directly to channels: white, yellow, cyan, green,
  // magenta, red, blue, black.
  assign bar        = 3'(h_cnt / 12'(BAR_W));
  assign pixel      = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  assign unused_rgb = ^{r, g, b};
`else
  assign pixel = {r, g, b};
`endif

  // One register stage keeps DE, both syncs and data mutually aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      hdmi_d  <= '0;
      hdmi_de <= 1'b0;
      hdmi_hs <= ~SYNC_POL;
      hdmi_vs <= ~SYNC_POL;
    end else begin
      hdmi_d  <= (active && !blank) ? pixel : 24'h000000;
      hdmi_de <= active;
      hdmi_hs <= hs_raw ? SYNC_POL : ~SYNC_POL;
      hdmi_vs <= vs_raw ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Inverted clock puts the transmitter's sampling edge mid-cycle.
  assign hdmi_clk = ~clk;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Self-checking bench for hdmi_timing_gen on a shrunken raster (80x31 clocks per frame).
// The reference model derives every output from the linear position in the frame.
module tb_hdmi_timing_gen;

  localparam int HA  = 64;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 4;
  localparam int VA  = 24;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int HT    = HA + HFP + HSW + HBP;
  localparam int VT    = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        blank = 1'b0;
  logic [7:0]  r = '0;
  logic [7:0]  g = '0;
  logic [7:0]  b = '0;
  logic [11:0] x;
  logic [11:0] y;
  logic        hdmi_clk;
  logic        hdmi_de;
  logic        hdmi_hs;
  logic        hdmi_vs;
  logic [23:0] hdmi_d;

  int checks   = 0;
  int failures = 0;
  int pos      = 0;

  // Expected {de, hs, vs, d}: pushed when stimulus is applied, popped one edge later.
  logic [26:0] exp_q[$];
  logic [26:0] exp_now;

`ifdef HDMI_TEST_PATTERN_EN
  logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  always #5 clk = ~clk;

  hdmi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .r(r), .g(g), .b(b),
    .hdmi_clk(hdmi_clk), .hdmi_d(hdmi_d), .hdmi_de(hdmi_de),
    .hdmi_hs(hdmi_hs), .blank(blank), .hdmi_vs(hdmi_vs)
  );

  function automatic logic [26:0] model(input int p, input logic rst, input logic blk,
                                        input logic [23:0] rgb);
    int px;
    int py;
    logic act;
    logic hs;
    logic vs;
    logic [23:0] d;
    px = p % HT;
    py = p / HT;
    if (rst) return {1'b0, 1'b1, 1'b1, 24'h000000};
    act = (px < HA) && (py < VA);
    hs  = !((px >= HA + HFP) && (px < HA + HFP + HSW));
    vs  = !((py >= VA + VFP) && (py < VA + VFP + VSW));
`ifdef HDMI_TEST_PATTERN_EN
    d = act ? bar_rgb[px / (HA / 8)] : 24'h000000;
`else
    d = rgb;
`endif
    return {act, hs, vs, (act && !blk) ? d : 24'h000000};
  endfunction

  // Drive one cycle of stimulus, advance one edge, update the model position.
  task automatic tick(input logic rst, input logic blk, input logic [23:0] rgb);
    reset = rst;
    blank = blk;
    {r, g, b} = rgb;
    exp_q.push_back(model(pos, rst, blk, rgb));
    @(posedge clk);
    #1;
    pos = rst ? 0 : (pos + 1) % FRAME;
    exp_now = exp_q.pop_front();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 24'($urandom));
      checks++;
      if (hdmi_de !== 1'b0 || hdmi_d !== 24'h0 || hdmi_hs !== 1'b1 || hdmi_vs !== 1'b1) begin
        failures++;
        $display("FAIL reset_outputs: got de=%b d=%h hs=%b vs=%b want de=0 d=000000 hs=1 vs=1",
                 hdmi_de, hdmi_d, hdmi_hs, hdmi_vs);
      end
      checks++;
      if (x !== 12'd0 || y !== 12'd0) begin
        failures++;
        $display("FAIL reset_xy: got x=%0d y=%0d want x=0 y=0", x, y);
      end
    end
    checks++;
    if (hdmi_clk !== 1'b0) begin
      failures++;
      $display("FAIL hdmi_clk_high_phase: got %b want 0", hdmi_clk);
    end
    #5;
    checks++;
    if (hdmi_clk !== 1'b1) begin
      failures++;
      $display("FAIL hdmi_clk_low_phase: got %b want 1", hdmi_clk);
    end
    tick(1'b0, 1'b0, 24'hA5C3E7);
    checks++;
    if (hdmi_de !== 1'b1 || hdmi_d !== exp_now[23:0] || x !== 12'd1 || y !== 12'd0) begin
      failures++;
      $display("FAIL first_pixel: got de=%b d=%h x=%0d y=%0d want de=1 d=%h x=1 y=0",
               hdmi_de, hdmi_d, x, y, exp_now[23:0]);
    end
    tick(1'b1, 1'b0, 24'h0);
    checks++;
    if (x !== 12'd0 || y !== 12'd0 || hdmi_de !== 1'b0) begin
      failures++;
      $display("FAIL rehome: got x=%0d y=%0d de=%b want x=0 y=0 de=0", x, y, hdmi_de);
    end
  endtask

  // mode 0: random rgb and sporadic blank; mode 1: constant rgb, blank window on line 3.
  task automatic test_frames(input int n, input int mode, input string tag);
    int de_cnt = 0;
    int hs_low = 0;
    int vs_low = 0;
    int hs_run = 0;
    int last_vs_fall = -1;
    int blank_zero = 0;
    logic prev_vs = 1'b1;
    for (int i = 0; i < n * FRAME; i++) begin
      logic blk;
      logic [23:0] rgb;
      int px;
      int py;
      px = pos % HT;
      py = pos / HT;
      if (mode == 0) begin
        rgb = 24'($urandom);
        blk = ($urandom_range(0, 7) == 0);
      end else begin
        rgb = 24'h123456;
        blk = (py == 3) && (px >= 10) && (px < 20);
      end
      tick(1'b0, blk, rgb);
      checks++;
      if (x !== 12'(pos % HT) || y !== 12'(pos / HT)) begin
        failures++;
        $display("FAIL %s xy: cycle %0d got x=%0d y=%0d want x=%0d y=%0d",
                 tag, i, x, y, pos % HT, pos / HT);
      end
      checks++;
      if ({hdmi_de, hdmi_hs, hdmi_vs} !== exp_now[26:24]) begin
        failures++;
        $display("FAIL %s de_hs_vs: cycle %0d got %b%b%b want %b", tag, i,
                 hdmi_de, hdmi_hs, hdmi_vs, exp_now[26:24]);
      end
      checks++;
      if (hdmi_d !== exp_now[23:0]) begin
        failures++;
        $display("FAIL %s data: cycle %0d got %h want %h", tag, i, hdmi_d, exp_now[23:0]);
      end
      if (hdmi_de) de_cnt++;
      if (hdmi_de && hdmi_d == 24'h0) blank_zero++;
      if (!hdmi_vs) vs_low++;
      if (!hdmi_hs) begin
        hs_low++;
        hs_run++;
      end else if (hs_run > 0) begin
        checks++;
        if (hs_run != HSW) begin
          failures++;
          $display("FAIL %s hs_width: got %0d want %0d", tag, hs_run, HSW);
        end
        hs_run = 0;
      end
      if (prev_vs && !hdmi_vs) begin
        if (last_vs_fall >= 0) begin
          checks++;
          if (i - last_vs_fall != FRAME) begin
            failures++;
            $display("FAIL %s frame_period: got %0d want %0d", tag, i - last_vs_fall, FRAME);
          end
        end
        last_vs_fall = i;
      end
      prev_vs = hdmi_vs;
    end
    checks++;
    if (de_cnt != n * HA * VA) begin
      failures++;
      $display("FAIL %s de_count: got %0d want %0d", tag, de_cnt, n * HA * VA);
    end
    checks++;
    if (hs_low != n * VT * HSW) begin
      failures++;
      $display("FAIL %s hs_low_total: got %0d want %0d", tag, hs_low, n * VT * HSW);
    end
    checks++;
    if (vs_low != n * VSW * HT) begin
      failures++;
      $display("FAIL %s vs_low_total: got %0d want %0d", tag, vs_low, n * VSW * HT);
    end
`ifndef HDMI_TEST_PATTERN_EN
    if (mode == 1) begin
      checks++;
      if (blank_zero != 10) begin
        failures++;
        $display("FAIL %s blank_pixels: got %0d want 10", tag, blank_zero);
      end
    end
`endif
  endtask

  // Reset lands while the hsync pulse is in progress on line 5.
  task automatic test_reset_mid();
    int target;
    target = 5 * HT + HA + HFP + 2;
    for (int i = 0; i < FRAME && pos != target; i++) tick(1'b0, 1'b0, 24'($urandom));
    checks++;
    if (hdmi_hs !== 1'b0 || pos != target) begin
      failures++;
      $display("FAIL mid_precondition: got hs=%b pos=%0d want hs=0 pos=%0d", hdmi_hs, pos, target);
    end
    tick(1'b1, 1'b0, 24'($urandom));
    checks++;
    if (x !== 12'd0 || y !== 12'd0) begin
      failures++;
      $display("FAIL mid_reset_xy: got x=%0d y=%0d want x=0 y=0", x, y);
    end
    checks++;
    if (hdmi_de !== 1'b0 || hdmi_d !== 24'h0 || hdmi_hs !== 1'b1 || hdmi_vs !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_outputs: got de=%b d=%h hs=%b vs=%b want de=0 d=000000 hs=1 vs=1",
               hdmi_de, hdmi_d, hdmi_hs, hdmi_vs);
    end
  endtask

  initial begin
    test_reset();
    test_frames(2, 0, "random");
    test_reset_mid();
    test_frames(1, 0, "after_reset");
    test_frames(1, 1, "blank");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
